// File: rtl/event_capture_4_if.sv
// Service handshake between the event capture stage and its consumer:
// the capture stage offers a channel index, the consumer accepts it.
interface event_capture_4_if;
    logic       svc_valid;
    logic [1:0] svc_id;
    logic       svc_ready;

    modport master (output svc_valid, output svc_id, input svc_ready);
    modport slave  (input svc_valid, input svc_id, output svc_ready);
endinterface

// File: rtl/event_capture_4.sv
// Four-channel rising-edge event capture with sticky pending flags, a
// fixed-priority valid/ready service offer and per-channel overrun counters.
module event_capture_4 #(
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          ev_in,
    input  logic [3:0]          mask,
    output logic [3:0]          pend,
    event_capture_4_if.master   svc,
    input  logic [1:0]          ovf_sel,
    output logic [CNT_W-1:0]    ovf_cnt
);
    typedef enum logic {ST_IDLE, ST_OFFER} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [1:0]       id_q, id_d;
    logic [3:0]       ev_prev_q;
    logic [3:0]       pend_q, pend_d;
    logic [3:0]       rise, acc, consume;
    logic             hs;
    logic [CNT_W-1:0] cnt_q [4];

    assign rise = ev_in & ~ev_prev_q;
    assign acc  = rise & ~mask;
    assign hs   = (state_q == ST_OFFER) && svc.svc_ready;

    assign pend          = pend_q;
    assign svc.svc_valid = (state_q == ST_OFFER);
    assign svc.svc_id    = id_q;
    assign ovf_cnt       = cnt_q[ovf_sel];

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_q != 4'b0000) begin
                    state_d = ST_OFFER;
                    if (pend_q[0])      id_d = 2'd0;
                    else if (pend_q[1]) id_d = 2'd1;
                    else if (pend_q[2]) id_d = 2'd2;
                    else                id_d = 2'd3;
                end
            end
            ST_OFFER: begin
                // id stays frozen for the whole offer, even if ch0 arrives
                if (svc.svc_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            id_q      <= 2'd0;
            ev_prev_q <= 4'b1111;
            pend_q    <= 4'b0000;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            ev_prev_q <= ev_in;
            pend_q    <= pend_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            assign consume[gi] = hs && (id_q == 2'(gi));
            // a new event in the consume cycle re-arms the flag
            assign pend_d[gi]  = acc[gi] | (pend_q[gi] & ~consume[gi]);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q[gi] <= '0;
                end else if (consume[gi]) begin
                    cnt_q[gi] <= '0;
                end else if (acc[gi] && pend_q[gi] && (cnt_q[gi] != CNT_MAX)) begin
                    cnt_q[gi] <= cnt_q[gi] + 1'b1;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_event_capture_4.sv
// Directed bench for event_capture_4: expected service ids go into a queue
// that a negedge monitor drains on every handshake; state is checked inline.
module tb_event_capture_4;
    logic       clk;
    logic       rst_n;
    logic [3:0] ev_in;
    logic [3:0] mask;
    logic [3:0] pend;
    logic [1:0] ovf_sel;
    logic [1:0] ovf_cnt;

    int errors = 0;
    int checks = 0;
    logic [1:0] exp_q [$];

    event_capture_4_if sif ();

    event_capture_4 #(.CNT_W(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ev_in   (ev_in),
        .mask    (mask),
        .pend    (pend),
        .svc     (sif),
        .ovf_sel (ovf_sel),
        .ovf_cnt (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] v);
        ev_in = v;
        step();
        ev_in = 4'b0000;
        step();
    endtask

    // handshake monitor: valid & ready seen mid-cycle completes at the next edge
    always @(negedge clk) begin
        if (sif.svc_valid === 1'b1 && sif.svc_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL handshake: got id %0d expected none", sif.svc_id);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (sif.svc_id !== e) begin
                    errors++;
                    $display("FAIL handshake: got id %0d expected %0d", sif.svc_id, e);
                end else begin
                    $display("ok   handshake id %0d", sif.svc_id);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        ev_in = 4'b0101;
        mask = 4'b0000;
        ovf_sel = 2'd0;
        sif.svc_ready = 1'b0;

        // 1: reset with lines already high
        step();
        step();
        check("rst_pend", 32'(pend), 32'h0);
        check("rst_valid", 32'(sif.svc_valid), 32'h0);
        check("rst_id", 32'(sif.svc_id), 32'h0);
        check("rst_cnt", 32'(ovf_cnt), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("held_high_quiet", {pend, 3'b000, sif.svc_valid}, 32'h0);
        end
        ev_in = 4'b0000;
        step();

        // 2: single event on ch2
        sif.svc_ready = 1'b1;
        exp_q.push_back(2'd2);
        ev_in = 4'b0100;
        step();
        ev_in = 4'b0000;
        check("t2_pend", 32'(pend), 32'h4);
        check("t2_valid0", 32'(sif.svc_valid), 32'h0);
        step();
        check("t2_valid1", 32'(sif.svc_valid), 32'h1);
        check("t2_id", 32'(sif.svc_id), 32'h2);
        step();
        check("t2_pend_clr", 32'(pend), 32'h0);
        check("t2_valid_clr", 32'(sif.svc_valid), 32'h0);

        // 3: ch1 and ch3 together, served in index order
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        ev_in = 4'b1010;
        step();
        ev_in = 4'b0000;
        check("t3_pend", 32'(pend), 32'ha);
        step();
        check("t3_offer1", {sif.svc_valid, sif.svc_id}, 32'h5);
        step();
        check("t3_gap", 32'(sif.svc_valid), 32'h0);
        check("t3_pend_mid", 32'(pend), 32'h8);
        step();
        check("t3_offer3", {sif.svc_valid, sif.svc_id}, 32'h7);
        step();
        check("t3_pend_end", 32'(pend), 32'h0);
        check("t3_valid_end", 32'(sif.svc_valid), 32'h0);

        // 4: overrun counting and saturation on ch0
        sif.svc_ready = 1'b0;
        ovf_sel = 2'd0;
        pulse(4'b0001);
        check("t4_pend", 32'(pend), 32'h1);
        check("t4_cnt0", 32'(ovf_cnt), 32'h0);
        pulse(4'b0001);
        check("t4_cnt1", 32'(ovf_cnt), 32'h1);
        pulse(4'b0001);
        check("t4_cnt2", 32'(ovf_cnt), 32'h2);
        pulse(4'b0001);
        check("t4_cnt3", 32'(ovf_cnt), 32'h3);
        pulse(4'b0001);
        check("t4_cnt_sat", 32'(ovf_cnt), 32'h3);
        check("t4_offer", {sif.svc_valid, sif.svc_id}, 32'h4);
        exp_q.push_back(2'd0);
        sif.svc_ready = 1'b1;
        step();
        sif.svc_ready = 1'b0;
        check("t4_cnt_clr", 32'(ovf_cnt), 32'h0);
        check("t4_pend_clr", 32'(pend), 32'h0);
        step();

        // 5: masked ch3, ch0 rise coinciding with its own handshake
        mask = 4'b1000;
        pulse(4'b0001);
        check("t5_offer", {sif.svc_valid, sif.svc_id}, 32'h4);
        pulse(4'b1000);
        pulse(4'b1000);
        check("t5_mask_pend", 32'(pend), 32'h1);
        ovf_sel = 2'd3;
        check("t5_mask_cnt", 32'(ovf_cnt), 32'h0);
        ovf_sel = 2'd0;
        pulse(4'b0001);
        check("t5_cnt_pre", 32'(ovf_cnt), 32'h1);
        exp_q.push_back(2'd0);
        sif.svc_ready = 1'b1;
        ev_in = 4'b0001;
        step();
        ev_in = 4'b0000;
        check("t5_set_wins", 32'(pend), 32'h1);
        check("t5_cnt_zero", 32'(ovf_cnt), 32'h0);
        check("t5_idle", 32'(sif.svc_valid), 32'h0);
        exp_q.push_back(2'd0);
        step();
        check("t5_reoffer", {sif.svc_valid, sif.svc_id}, 32'h4);
        step();
        sif.svc_ready = 1'b0;
        check("t5_pend_end", 32'(pend), 32'h0);
        mask = 4'b0000;
        step();

        // 6: reset in the middle of an offer
        ovf_sel = 2'd1;
        pulse(4'b0010);
        pulse(4'b0010);
        check("t6_offer", {sif.svc_valid, sif.svc_id}, 32'h5);
        check("t6_cnt", 32'(ovf_cnt), 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t6_valid", 32'(sif.svc_valid), 32'h0);
        check("t6_pend", 32'(pend), 32'h0);
        check("t6_cnt_rst", 32'(ovf_cnt), 32'h0);
        step();
        step();
        check("t6_stays_idle", 32'(sif.svc_valid), 32'h0);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
